tv80_bus_seq: RTL and testbench

TV80_BUS_SEQ -- requirements
Module: tv80_bus_seq

---
 rtl/tv80_bus_pkg.sv | 80 ++++++++
 rtl/tv80_bus_wait.sv | 30 +++
 rtl/tv80_bus_seq.sv | 146 ++++++++++++++
 tb/tb_tv80_bus_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tv80_bus_pkg.sv
// Shared types for the TV80 bus cycle sequencer:
// bus states, cycle kinds and the strobe decode.
package tv80_bus_pkg;

  typedef enum logic [2:0] {
    IDLE, T1, T2, TW, T3, RF
  } bus_state_t;

  typedef enum logic [2:0] {
    MEMRD, MEMWR, IORD, IOWR, INTA, FETCH
  } cyc_t;

  typedef struct packed {
    logic m1_n;
    logic mreq_n;
    logic iorq_n;
    logic rd_n;
    logic wr_n;
    logic rfsh_n;
  } strb_t;

  localparam int WCW = 3;
  localparam strb_t STRB_OFF = '1;

  function automatic cyc_t cyc_decode(
    input logic m1,
    input logic io,
    input logic we
  );
    cyc_t c;
    if (m1)
      c = io ? INTA : FETCH;
    else if (io)
      c = we ? IOWR : IORD;
    else
      c = we ? MEMWR : MEMRD;
    return c;
  endfunction

  function automatic logic cyc_is_wr(input cyc_t c);
    return (c == MEMWR) || (c == IOWR);
  endfunction

  function automatic logic cyc_is_io(input cyc_t c);
    return (c == IORD) || (c == IOWR);
  endfunction

  function automatic strb_t strb_decode(
    input bus_state_t s,
    input cyc_t       c,
    input logic       t2w
  );
    strb_t r;
    logic  act;
    r   = STRB_OFF;
    act = (s == T2) || (s == TW) || (s == T3);
    if (s == RF) begin
      r.mreq_n = 1'b0;
      r.rfsh_n = 1'b0;
    end else if (s != IDLE) begin
      if (c == FETCH || c == INTA)
        r.m1_n = 1'b0;
      // INTA keeps iorq off during T2 so the vector is fetched late
      if (c == INTA) begin
        r.iorq_n = !((s == TW) || (s == T3));
      end else if (act) begin
        if (cyc_is_io(c))
          r.iorq_n = 1'b0;
        else
          r.mreq_n = 1'b0;
        if (cyc_is_wr(c))
          r.wr_n = !(t2w || (s == T3));
        else
          r.rd_n = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tv80_bus_wait.sv
// Wait-state counter: loads on T2 entry,
// decrements per TW cycle, saturates at zero.
module tv80_bus_wait
  import tv80_bus_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           cen,
  input  logic           load,
  input  logic           dec,
  input  logic [WCW-1:0] load_val,
  output logic           zero
);

  logic [WCW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cen) begin
      if (load)
        cnt <= load_val;
      else if (dec && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tv80_bus_seq.sv
// TV80 bus cycle sequencer: T-state machine with
// registered strobes, wait states and DRAM refresh.
module tv80_bus_seq
  import tv80_bus_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int MEM_WAIT   = 0,
  parameter int IO_WAIT    = 1,
  parameter int T2WRITE    = 1,
  parameter int REFRESH_EN = 1,
  parameter int RFSH_BITS  = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cen,
  input  logic          req,
  input  logic          m1,
  input  logic          io,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic          busy,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] A,
  output logic [DW-1:0] dout,
  input  logic [DW-1:0] di,
  input  logic          wait_n,
  output logic          m1_n,
  output logic          mreq_n,
  output logic          iorq_n,
  output logic          rd_n,
  output logic          wr_n,
  output logic          rfsh_n
);

  localparam logic [WCW-1:0] MEM_WV  = WCW'(MEM_WAIT);
  localparam logic [WCW-1:0] IO_WV   = WCW'(IO_WAIT);
  localparam logic [WCW-1:0] INTA_WV =
    (IO_WAIT > 2) ? WCW'(IO_WAIT) : WCW'(2);

  bus_state_t           state, nstate;
  cyc_t                 cyc_q, ncyc;
  strb_t                strb_q;
  logic                 relatch;
  logic [RFSH_BITS-1:0] rfsh_cnt;
  logic [WCW-1:0]       wload_val;
  logic                 wzero;
  logic                 wload;
  logic                 wdec;

  always_comb begin
    nstate  = state;
    relatch = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          nstate  = T1;
          relatch = 1'b1;
        end
      end
      T1: nstate = T2;
      T2, TW: nstate = (!wzero || !wait_n) ? TW : T3;
      T3: begin
        if (REFRESH_EN != 0 && cyc_q == FETCH) begin
          nstate = RF;
        end else if (req) begin
          nstate  = T1;
          relatch = 1'b1;
        end else begin
          nstate = IDLE;
        end
      end
      RF: begin
        if (req) begin
          nstate  = T1;
          relatch = 1'b1;
        end else begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
    ncyc = relatch ? cyc_decode(m1, io, we) : cyc_q;
  end

  always_comb begin
    wload_val = MEM_WV;
    if (cyc_q == INTA)
      wload_val = INTA_WV;
    else if (cyc_is_io(cyc_q))
      wload_val = IO_WV;
  end

  assign wload = (state == T1);
  assign wdec  = (nstate == TW);

  tv80_bus_wait u_wait (
    .clk      (clk),
    .reset_n  (reset_n),
    .cen      (cen),
    .load     (wload),
    .dec      (wdec),
    .load_val (wload_val),
    .zero     (wzero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cyc_q    <= MEMRD;
      strb_q   <= STRB_OFF;
      ack      <= 1'b0;
      busy     <= 1'b0;
      A        <= '0;
      dout     <= '0;
      rdata    <= '0;
      rfsh_cnt <= '0;
    end else if (cen) begin
      state  <= nstate;
      cyc_q  <= ncyc;
      strb_q <= strb_decode(nstate, ncyc, T2WRITE != 0);
      busy   <= (nstate != IDLE);
      ack    <= (state == T3);
      if (relatch) begin
        A    <= addr;
        dout <= wdata;
      end else if (nstate == RF) begin
        A <= AW'(rfsh_cnt);
      end
      if (state == T3 && !cyc_is_wr(cyc_q))
        rdata <= di;
      if (state == RF)
        rfsh_cnt <= rfsh_cnt + 1'b1;
    end
  end

  assign m1_n   = strb_q.m1_n;
  assign mreq_n = strb_q.mreq_n;
  assign iorq_n = strb_q.iorq_n;
  assign rd_n   = strb_q.rd_n;
  assign wr_n   = strb_q.wr_n;
  assign rfsh_n = strb_q.rfsh_n;

endmodule

// File: tb/tb_tv80_bus_seq.sv
// Bench for tv80_bus_seq: vector table, scoreboard
// on ack, reset abort and a refresh-wrap fetch stream.
module tb_tv80_bus_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cen = 1'b1;
  logic        req = 1'b0;
  logic        m1 = 1'b0;
  logic        io = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  di = '0;
  logic        wait_n = 1'b1;

  logic        ack0, busy0, m1_n0, mreq_n0, iorq_n0;
  logic        rd_n0, wr_n0, rfsh_n0;
  logic [7:0]  rdata0, dout0;
  logic [15:0] a0;
  logic        ack1, busy1, m1_n1, mreq_n1, iorq_n1;
  logic        rd_n1, wr_n1, rfsh_n1;
  logic [7:0]  rdata1, dout1;
  logic [15:0] a1;

  always #5 clk = ~clk;

  tv80_bus_seq u_dut (
    .clk(clk), .reset_n(reset_n), .cen(cen),
    .req(req), .m1(m1), .io(io), .we(we),
    .addr(addr), .wdata(wdata),
    .ack(ack0), .busy(busy0), .rdata(rdata0),
    .A(a0), .dout(dout0), .di(di), .wait_n(wait_n),
    .m1_n(m1_n0), .mreq_n(mreq_n0), .iorq_n(iorq_n0),
    .rd_n(rd_n0), .wr_n(wr_n0), .rfsh_n(rfsh_n0)
  );

  tv80_bus_seq #(.IO_WAIT(0), .T2WRITE(0)) u_alt (
    .clk(clk), .reset_n(reset_n), .cen(cen),
    .req(req), .m1(m1), .io(io), .we(we),
    .addr(addr), .wdata(wdata),
    .ack(ack1), .busy(busy1), .rdata(rdata1),
    .A(a1), .dout(dout1), .di(di), .wait_n(wait_n),
    .m1_n(m1_n1), .mreq_n(mreq_n1), .iorq_n(iorq_n1),
    .rd_n(rd_n1), .wr_n(wr_n1), .rfsh_n(rfsh_n1)
  );

  typedef struct packed {
    logic ack, busy, m1_n, mreq_n, iorq_n;
    logic rd_n, wr_n, rfsh_n;
    logic [15:0] a;
    logic [7:0] dout, rdata;
  } obs_t;

  obs_t o0, o1, o;
  bit   sel = 1'b0;

  assign o0 = {ack0, busy0, m1_n0, mreq_n0, iorq_n0,
               rd_n0, wr_n0, rfsh_n0, a0, dout0, rdata0};
  assign o1 = {ack1, busy1, m1_n1, mreq_n1, iorq_n1,
               rd_n1, wr_n1, rfsh_n1, a1, dout1, rdata1};
  assign o  = sel ? o1 : o0;

  typedef struct {
    string       name;
    int          alt, ctog, vm1, vio, vwe;
    logic [15:0] vaddr;
    logic [7:0]  vwdata, vdi;
    int          wlo;
    int          lat, m1c, mrc, ioc, rdc, wrc, rfc, ackc;
  } vec_t;

  vec_t       tbl[10];
  logic [7:0] sb[$];
  logic [7:0] model = '0;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic sb_mon();
    logic       prev = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (ack0 && !prev) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_rdata", int'(rdata0), int'(e));
        end
      end
      prev = ack0;
    end
  endtask

  task automatic do_txn(input vec_t v);
    int lat = 0, m1c = 0, mrc = 0, ioc = 0, rdc = 0;
    int wrc = 0, rfc = 0, ackc = 0, abad = 0;
    bit seen = 1'b0;
    sel = (v.alt != 0);
    @(negedge clk);
    m1 = (v.vm1 != 0);
    io = (v.vio != 0);
    we = (v.vwe != 0);
    addr = v.vaddr;
    wdata = v.vwdata;
    di = v.vdi;
    cen = 1'b1;
    wait_n = 1'b1;
    req = 1'b1;
    if (v.vwe == 0) model = v.vdi;
    sb.push_back(model);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!o.m1_n) m1c++;
      if (!o.mreq_n && o.rfsh_n) mrc++;
      if (!o.iorq_n) ioc++;
      if (!o.rd_n) rdc++;
      if (!o.wr_n) wrc++;
      if (!o.rfsh_n) rfc++;
      if (o.busy && o.rfsh_n &&
          (o.a != v.vaddr || o.dout != v.vwdata))
        abad++;
      if (o.ack) begin
        ackc++;
        if (!seen) lat = k;
        seen = 1'b1;
      end
      if (seen && !ack0 && !ack1 && !busy0 && !busy1)
        break;
      req = 1'b0;
      if (k == 2) begin
        addr = ~v.vaddr;
        wdata = ~v.vwdata;
        m1 = ~m1;
        io = ~io;
        we = ~we;
      end
      if (v.ctog != 0) cen = (k % 2 == 0);
      wait_n = !(v.wlo > 0 && k >= 2 && k <= 1 + v.wlo);
    end
    cen = 1'b1;
    wait_n = 1'b1;
    chk({v.name, "_done"}, int'(seen), 1);
    chk({v.name, "_lat"}, lat, v.lat);
    chk({v.name, "_m1"}, m1c, v.m1c);
    chk({v.name, "_mreq"}, mrc, v.mrc);
    chk({v.name, "_iorq"}, ioc, v.ioc);
    chk({v.name, "_rd"}, rdc, v.rdc);
    chk({v.name, "_wr"}, wrc, v.wrc);
    chk({v.name, "_rfsh"}, rfc, v.rfc);
    chk({v.name, "_ack"}, ackc, v.ackc);
    chk({v.name, "_addr"}, abad, 0);
    chk({v.name, "_rdata"}, int'(o.rdata), int'(model));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, rf, acks, late, idle;
    bit done;

    tbl[0] = '{"memrd", 0, 0, 0, 0, 0, 16'h1234, 8'h00,
               8'hA5, 0, 4, 0, 2, 0, 2, 0, 0, 1};
    tbl[1] = '{"memwr_t2", 0, 0, 0, 0, 1, 16'h8000, 8'h3C,
               8'h00, 0, 4, 0, 2, 0, 0, 2, 0, 1};
    tbl[2] = '{"memwr_t3", 1, 0, 0, 0, 1, 16'h8000, 8'h3C,
               8'h00, 0, 4, 0, 2, 0, 0, 1, 0, 1};
    tbl[3] = '{"iord_w3", 0, 0, 0, 1, 0, 16'h00A0, 8'h00,
               8'h6B, 3, 7, 0, 0, 5, 5, 0, 0, 1};
    tbl[4] = '{"iord", 0, 0, 0, 1, 0, 16'h0010, 8'h00,
               8'h81, 0, 5, 0, 0, 3, 3, 0, 0, 1};
    tbl[5] = '{"iowr", 0, 0, 0, 1, 1, 16'h00FE, 8'h77,
               8'h00, 0, 5, 0, 0, 3, 0, 3, 0, 1};
    tbl[6] = '{"inta", 1, 0, 1, 1, 0, 16'h0038, 8'h00,
               8'hFF, 0, 6, 5, 0, 3, 0, 0, 0, 1};
    tbl[7] = '{"fetch", 0, 0, 1, 0, 0, 16'h0100, 8'h00,
               8'h3E, 0, 4, 3, 2, 0, 2, 0, 1, 1};
    tbl[8] = '{"cen_tog", 0, 1, 0, 0, 0, 16'h2222, 8'h00,
               8'hC3, 0, 7, 0, 4, 0, 4, 0, 0, 2};
    tbl[9] = '{"memrd_max", 0, 0, 0, 0, 0, 16'hFFFF, 8'h00,
               8'h00, 0, 4, 0, 2, 0, 2, 0, 0, 1};

    fork
      sb_mon();
    join_none

    repeat (2) @(negedge clk);
    chk("rst_strobes", int'({m1_n0, mreq_n0, iorq_n0,
        rd_n0, wr_n0, rfsh_n0}), 63);
    chk("rst_ack", int'(ack0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_a", int'(a0), 0);
    chk("rst_dout", int'(dout0), 0);
    chk("rst_rdata", int'(rdata0), 0);
    reset_n = 1'b1;

    foreach (tbl[i]) do_txn(tbl[i]);

    // abort an I/O read stuck in TW
    sel = 1'b0;
    @(negedge clk);
    m1 = 1'b0; io = 1'b1; we = 1'b0;
    addr = 16'h0042; wdata = 8'h11; di = 8'h99;
    wait_n = 1'b0;
    req = 1'b1;
    sb.push_back(8'h99);
    repeat (4) begin
      @(negedge clk);
      req = 1'b0;
    end
    chk("abort_pre_iorq", int'(iorq_n0), 0);
    chk("abort_pre_busy", int'(busy0), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_strobes", int'({m1_n0, mreq_n0, iorq_n0,
        rd_n0, wr_n0, rfsh_n0}), 63);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_a", int'(a0), 0);
    chk("abort_rdata", int'(rdata0), 0);
    sb.delete();
    model = '0;
    wait_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack0 || busy0 || ack1 || busy1) cnt++;
    end
    chk("abort_no_ack", cnt, 0);

    // 130 back-to-back fetches; refresh counter wraps at 128
    @(negedge clk);
    m1 = 1'b1; io = 1'b0; we = 1'b0;
    addr = 16'h4000; wdata = 8'h00; di = 8'h5A;
    req = 1'b1;
    model = 8'h5A;
    sb.push_back(model);
    rf = 0; acks = 0; late = 0; idle = 0;
    done = 1'b0;
    for (int k = 0; k < 800 && !done; k++) begin
      @(negedge clk);
      if (ack0) acks++;
      if (!rfsh_n0) begin
        if (rf >= 126) begin
          chk($sformatf("rf_a%0d", rf), int'(a0), rf % 128);
          if (ack0) late++;
        end
        rf++;
        if (rf < 130) begin
          addr = addr + 16'd1;
          sb.push_back(model);
        end else begin
          req = 1'b0;
        end
      end else if (!busy0) begin
        if (rf >= 130) done = 1'b1;
        else idle++;
      end
    end
    chk("stream_done", int'(done), 1);
    chk("stream_acks", acks, 130);
    chk("stream_late_acks", late, 4);
    chk("stream_idle", idle, 0);
    chk("stream_rdata", int'(rdata0), 8'h5A);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
